lc3_muldiv_unit: RTL and testbench



---
 rtl/lc3_muldiv_unit.sv | 191 +++++++++++++++++++
 tb/tb_lc3_muldiv_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lc3_muldiv_unit.sv
// -----------------------------------------------------------------------------
// lc3_muldiv_unit
//
// Multi-cycle unsigned multiply / divide unit feeding the register-file write
// port. Operands are latched when a request is accepted. The unit then runs
// WIDTH iterations of shift-add multiply or restoring divide, and finally
// issues a one-cycle register-file write.
//
// Ports
//   clk       rising-edge clock, shared with the register file
//   rst       synchronous active-high reset; aborts any operation in flight
//   start     request, accepted only while busy = 0
//   op        00 product low, 01 product high, 10 quotient, 11 remainder
//   a         multiplicand / dividend (SR1 read data)
//   b         multiplier / divisor (SR2 read data)
//   dst       destination register specifier
//   busy      high from the cycle after acceptance through the write-back cycle
//   done      one-cycle completion pulse, coincident with RegWE
//   div_zero  divide-by-zero flag of the last operation
//   RegWE     register-file write enable (one-cycle pulse)
//   DR        register-file write address (holds its last value)
//   DR_value  register-file write data (holds its last value)
// -----------------------------------------------------------------------------
module lc3_muldiv_unit #(
   parameter int WIDTH      = 16,
   parameter int REG_ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [WIDTH-1:0]      a,
   input  logic [WIDTH-1:0]      b,
   input  logic [REG_ADDR_W-1:0] dst,
   output logic                  busy,
   output logic                  done,
   output logic                  div_zero,
   output logic                  RegWE,
   output logic [REG_ADDR_W-1:0] DR,
   output logic [WIDTH-1:0]      DR_value
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_WB   = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [WIDTH-1:0]        a_q, a_d;
   logic [WIDTH-1:0]        b_q, b_d;
   logic [1:0]              op_q, op_d;
   logic [REG_ADDR_W-1:0]   dst_q, dst_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   // hi_q: upper product half (multiply) or partial remainder (divide).
   // lo_q: multiplier shifting out (multiply) or dividend/quotient (divide).
   logic [WIDTH-1:0]        hi_q, hi_d;
   logic [WIDTH-1:0]        lo_q, lo_d;
   logic                    dz_q, dz_d;
   logic                    we_q, we_d;
   logic [REG_ADDR_W-1:0]   dr_q, dr_d;
   logic [WIDTH-1:0]        val_q, val_d;

   // Multiply step: add the multiplicand when the current multiplier bit is
   // set. Then shift {carry, hi, lo} right by one place.
   logic [WIDTH-1:0]        mul_addend;
   logic [WIDTH:0]          mul_sum;
   assign mul_addend = lo_q[0] ? a_q : '0;
   assign mul_sum    = {1'b0, hi_q} + {1'b0, mul_addend};

   // Restoring divide step: the partial remainder takes in the next dividend
   // bit, so it needs WIDTH+1 bits. When the trial subtraction succeeds, the
   // difference is below the divisor and fits in WIDTH bits again.
   logic [WIDTH:0]          div_shift;
   logic                    div_ge;
   logic [WIDTH-1:0]        div_diff;
   assign div_shift = {hi_q, lo_q[WIDTH-1]};
   assign div_ge    = (div_shift >= {1'b0, b_q});
   assign div_diff  = div_shift[WIDTH-1:0] - b_q;

   logic                    div_by_zero;
   assign div_by_zero = op_q[1] && (b_q == '0);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dz_d    = dz_q;
      we_d    = 1'b0;
      dr_d    = dr_q;
      val_d   = val_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               op_d    = op;
               dst_d   = dst;
               cnt_d   = '0;
               dz_d    = 1'b0;
               hi_d    = '0;
               lo_d    = op[1] ? a : b;
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            if (div_by_zero) begin
               // A zero divisor skips the iterations entirely.
               dz_d    = 1'b1;
               we_d    = 1'b1;
               dr_d    = dst_q;
               val_d   = op_q[0] ? a_q : '1;
               state_d = S_WB;
            end else begin
               if (op_q[1]) begin
                  hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                  lo_d = {lo_q[WIDTH-2:0], div_ge};
               end else begin
                  hi_d = mul_sum[WIDTH:1];
                  lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
               end
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_ITER) begin
                  // op[0] selects the upper register for both MULH and REM,
                  // and the lower register for both MULL and DIV.
                  we_d    = 1'b1;
                  dr_d    = dst_q;
                  val_d   = op_q[0] ? hi_d : lo_d;
                  state_d = S_WB;
               end
            end
         end

         S_WB: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dz_q    <= 1'b0;
         we_q    <= 1'b0;
         dr_q    <= '0;
         val_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dz_q    <= dz_d;
         we_q    <= we_d;
         dr_q    <= dr_d;
         val_q   <= val_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = we_q;
   assign RegWE    = we_q;
   assign div_zero = dz_q;
   assign DR       = dr_q;
   assign DR_value = val_q;

endmodule

// File: tb/tb_lc3_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_lc3_muldiv_unit
//
// Scoreboard bench for lc3_muldiv_unit. The stimulus process pushes the
// expected write for every accepted request, including the cycle in which the
// write is expected. A monitor on the falling edge pops one entry per write
// pulse and checks it. Expected values come from plain arithmetic on the
// operands.
// -----------------------------------------------------------------------------
module tb_lc3_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [15:0] a, b;
   logic [2:0]  dst;
   logic        busy, done, div_zero, RegWE;
   logic [2:0]  DR;
   logic [15:0] DR_value;

   lc3_muldiv_unit #(.WIDTH(16), .REG_ADDR_W(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .dst      (dst),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .RegWE    (RegWE),
      .DR       (DR),
      .DR_value (DR_value)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2:0]  dr;
      logic [15:0] val;
      logic        dz;
      int          at;
   } exp_t;

   exp_t exp_q[$];
   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: plain unsigned arithmetic on the operands.
   function automatic exp_t model(input logic [15:0] ra, input logic [15:0] rb,
                                  input logic [1:0] rop, input logic [2:0] rdst);
      exp_t e;
      int unsigned prod;
      prod  = int'(ra) * int'(rb);
      e.dr  = rdst;
      e.dz  = 1'b0;
      e.at  = 0;
      case (rop)
         2'b00: e.val = prod[15:0];
         2'b01: e.val = prod[31:16];
         2'b10: if (rb == 0) begin e.val = 16'hFFFF; e.dz = 1'b1; end
                else e.val = ra / rb;
         default: if (rb == 0) begin e.val = ra; e.dz = 1'b1; end
                  else e.val = ra % rb;
      endcase
      return e;
   endfunction

   // Monitor: every write pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (RegWE === 1'b1 || done === 1'b1)) begin
         chk("done_eq_we", {31'd0, done}, {31'd0, RegWE});
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("DR", {29'd0, DR}, {29'd0, e.dr});
            chk("DR_value", {16'd0, DR_value}, {16'd0, e.val});
            chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
            chk("write_cycle", cyc, e.at);
            chk("busy_in_wb", {31'd0, busy}, 32'd1);
         end
      end
   end

   // Wait for the unit to be idle, then present one request for one edge.
   task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                        input logic [1:0] iop, input logic [2:0] idst);
      exp_t e;
      int   n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("idle_timeout", 32'd1, 32'd0);
      a = ia; b = ib; op = iop; dst = idst; start = 1'b1;
      e = model(ia, ib, iop, idst);
      e.at = cyc + ((iop[1] && ib == 0) ? 2 : 17);
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
      // Disturb the inputs; the operation in flight must not notice.
      a = 16'($urandom); b = 16'($urandom); op = 2'($urandom); dst = 3'($urandom);
   endtask

   // Hold start high during the write-back cycle; the request must be dropped.
   task automatic poke_in_wb();
      int n = 0;
      while (RegWE !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) chk("wb_timeout", 32'd1, 32'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; dst = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_we", {31'd0, RegWE}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_dz", {31'd0, div_zero}, 32'd0);
      chk("rst_DR", {29'd0, DR}, 32'd0);
      chk("rst_val", {16'd0, DR_value}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      issue(16'h1234, 16'h0010, 2'b00, 3'd3);
      issue(16'hFFFF, 16'hFFFF, 2'b01, 3'd1);
      issue(16'hFFFF, 16'hFFFF, 2'b00, 3'd4);
      issue(16'd100, 16'd7, 2'b10, 3'd5);
      issue(16'd100, 16'd7, 2'b11, 3'd6);
      issue(16'h1234, 16'h0000, 2'b10, 3'd7);
      issue(16'h1234, 16'h0000, 2'b11, 3'd0);
      repeat (3) @(negedge clk);
      chk("dz_hold", {31'd0, div_zero}, 32'd1);

      // A start pulse sampled at E5 of a running operation is ignored.
      issue(16'd3, 16'd5, 2'b00, 3'd2);
      repeat (4) @(negedge clk);
      a = 16'h7777; b = 16'h0003; dst = 3'd7; op = 2'b11; start = 1'b1;
      @(negedge clk);
      start = 1'b0;

      // A reset at E8 of a divide aborts it with no write.
      issue(16'hBEEF, 16'h0013, 2'b10, 3'd4);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      void'(exp_q.pop_back());
      @(negedge clk);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_we", {31'd0, RegWE}, 32'd0);
      chk("abort_val", {16'd0, DR_value}, 32'd0);
      chk("abort_DR", {29'd0, DR}, 32'd0);
      rst = 1'b0;
      issue(16'd1000, 16'd33, 2'b11, 3'd6);

      for (int i = 0; i < 40; i++) begin
         logic [15:0] ra, rb;
         ra = 16'($urandom);
         case ($urandom_range(0, 3))
            0: rb = 16'd0;
            1: rb = 16'($urandom_range(1, 15));
            default: rb = 16'($urandom);
         endcase
         issue(ra, rb, 2'($urandom), 3'($urandom));
         if ($urandom_range(0, 3) == 0) poke_in_wb();
      end

      begin
         int n = 0;
         while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
         end
      end
      repeat (3) @(negedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
